sram_ctl: RTL and testbench

Parametrised single-port SRAM controller: a synchronous word-addressed array behind a valid/ready request channel and an in-order valid/ready response channel, with byte-lane write enables, out-of-range detection and a hardware clear of the whole array after reset. It is the next-generation replacement for the fixed 64-bit, write-enable-only `sram` block and is the storage element that the SRAM controller's bus-side logic talks to.

---
 rtl/sram_ctl_pkg.sv | 23 ++
 rtl/sram_ctl_if.sv | 49 ++++
 rtl/sram_ctl_rsp_fifo.sv | 57 +++++
 rtl/sram_ctl.sv | 176 +++++++++++++++++
 tb/tb_sram_ctl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_ctl_pkg
// Brief   : Shared state encoding, response-queue sizing and byte parity.
// Rev     : 1.0
// ============================================================================
package sram_ctl_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int RSP_FIFO_DEPTH = 2;
    localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

    // Even parity: stored bit makes the byte plus parity an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctl_if.sv
`default_nettype none
// ============================================================================
// Interface : sram_ctl_if
// Brief     : Request/response channels of the SRAM controller.
//             SRAM_CTL_PARITY_EN adds the par_inject request-side signal.
// Rev       : 1.0
// ============================================================================
interface sram_ctl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 25
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;
`ifdef SRAM_CTL_PARITY_EN
    logic                  par_inject;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, par_inject,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, par_inject,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/sram_ctl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module : sram_ctl_rsp_fifo
// Brief  : Small in-order response queue holding {err, rdata} with occupancy.
// Rev    : 1.0
// ============================================================================
module sram_ctl_rsp_fifo
    import sram_ctl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_err,
    input  logic [DATA_W-1:0]     push_rdata,
    input  logic                  pop,
    output logic                  valid,
    output logic                  head_err,
    output logic [DATA_W-1:0]     head_rdata,
    output logic [RSP_CNT_W-1:0]  count
);

    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    logic [DATA_W:0]       r_entry [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [RSP_CNT_W-1:0]  r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_entry[r_wr_ptr] <= {push_err, push_rdata};
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + RSP_CNT_W'(push) - RSP_CNT_W'(pop);
        end
    end

    // Head is forced to zero while empty so idle outputs read as zero.
    assign valid                  = (r_count != '0);
    assign {head_err, head_rdata} = valid ? r_entry[r_rd_ptr] : '0;
    assign count                  = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_ctl.sv
`default_nettype none
// ============================================================================
// Module : sram_ctl
// Brief  : Single-port SRAM controller: cleared array, byte-lane writes,
//          range checking, in-order responses. SRAM_CTL_PARITY_EN adds
//          per-byte even parity with error injection.
// Rev    : 1.0
// ============================================================================
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 25,
    parameter int DEPTH  = 32
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctl_if.slave   bus
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_init_cnt;
    logic [IDX_W-1:0]       w_init_cnt_nxt;
    logic                   w_init_wr;

    logic [DATA_W-1:0]      r_mem [DEPTH];
`ifdef SRAM_CTL_PARITY_EN
    logic [NB-1:0]          r_par [DEPTH];
`endif

    logic                   w_run;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_accept;
    logic                   w_wr;
    logic                   w_pop;
    logic                   w_occ_space;
    logic [DATA_W-1:0]      w_rd_word;
    logic                   w_rd_err;

    logic                   r_inf_valid;
    logic                   r_inf_err;
    logic [DATA_W-1:0]      r_inf_rdata;

    logic                   w_fifo_valid;
    logic                   w_fifo_err;
    logic [DATA_W-1:0]      w_fifo_rdata;
    logic [RSP_CNT_W-1:0]   w_fifo_count;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_init_wr      = 1'b0;
        case (r_state)
            INIT: begin
                w_init_wr = 1'b1;
                if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + IDX_W'(1);
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    assign w_run = (r_state == RUN);

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    // Extra top bit keeps the compare exact when DEPTH == 2**ADDR_W.
    assign w_in_range  = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_idx       = bus.req_addr[IDX_W-1:0];
    assign w_pop       = w_fifo_valid && bus.rsp_ready;
    assign w_occ_space = (int'(w_fifo_count) + int'(r_inf_valid)) < RSP_FIFO_DEPTH;
    assign bus.req_ready = w_run && (w_occ_space || w_pop);
    assign w_accept    = bus.req_valid && bus.req_ready;
    assign w_wr        = w_accept && bus.req_we && w_in_range;

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_init_cnt] <= '0;
`ifdef SRAM_CTL_PARITY_EN
            r_par[r_init_cnt] <= {NB{byte_parity(8'h00)}};
`endif
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
`ifdef SRAM_CTL_PARITY_EN
                    r_par[w_idx][i] <= byte_parity(bus.req_wdata[8*i +: 8]) ^ bus.par_inject;
`endif
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];

`ifdef SRAM_CTL_PARITY_EN
    logic [NB-1:0] w_rd_par;

    always_comb begin
        w_rd_err = 1'b0;
        w_rd_par = r_par[w_idx];
        for (int i = 0; i < NB; i++) begin
            if (byte_parity(w_rd_word[8*i +: 8]) != w_rd_par[i]) begin
                w_rd_err = 1'b1;
            end
        end
    end
`else
    assign w_rd_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // In-flight stage: response formed on the acceptance edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inf_valid <= 1'b0;
            r_inf_err   <= 1'b0;
            r_inf_rdata <= '0;
        end else begin
            r_inf_valid <= w_accept;
            if (w_accept) begin
                r_inf_err   <= !w_in_range || (!bus.req_we && w_rd_err);
                r_inf_rdata <= (w_in_range && !bus.req_we) ? w_rd_word : '0;
            end
        end
    end

    sram_ctl_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (r_inf_valid),
        .push_err   (r_inf_err),
        .push_rdata (r_inf_rdata),
        .pop        (w_pop),
        .valid      (w_fifo_valid),
        .head_err   (w_fifo_err),
        .head_rdata (w_fifo_rdata),
        .count      (w_fifo_count)
    );

    assign bus.rsp_valid = w_fifo_valid;
    assign bus.rsp_err   = w_fifo_err;
    assign bus.rsp_rdata = w_fifo_rdata;
    assign bus.init_done = w_run;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_ctl
// Brief  : Directed + random bench for sram_ctl against a behavioural model
//          (word array plus expected-response queue). Honours SRAM_CTL_PARITY_EN.
// Rev    : 1.0
// ============================================================================
module tb_sram_ctl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 25;
    localparam int DEPTH  = 32;
    localparam int NB     = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sram_ctl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                acc_edge;
    } rsp_t;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   edge_no  = 0;
    int   rel_edge = 0;
    rsp_t exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [NB-1:0]     ref_bad [DEPTH];

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_bad[i] = '0;
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
    endtask

    task automatic set_inject(input logic inj);
`ifdef SRAM_CTL_PARITY_EN
        bus.par_inject = inj;
`else
        if (inj) $display("note: parity injection requested in a build without parity");
`endif
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic run, exp_valid, pop, exp_ready, acc;
        rsp_t r;
        int   a;
        #3;
        run       = (edge_no - rel_edge) >= DEPTH;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].acc_edge < edge_no);
        chk("init_done", bus.init_done, run);
        chk("rsp_valid", bus.rsp_valid, exp_valid);
        if (exp_valid) begin
            chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
            chk("rsp_err", bus.rsp_err, exp_q[0].err);
        end
        pop       = exp_valid && bus.rsp_ready;
        exp_ready = run && ((exp_q.size() < 2) || pop);
        chk("req_ready", bus.req_ready, exp_ready);
        acc = bus.req_valid && exp_ready;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            r.acc_edge = edge_no + 1;
            r.rdata    = '0;
            r.err      = 1'b0;
            if (bus.req_addr >= DEPTH) begin
                r.err = 1'b1;
            end else begin
                a = int'(bus.req_addr);
                if (bus.req_we) begin
                    for (int i = 0; i < NB; i++) begin
                        if (bus.req_be[i]) begin
                            ref_mem[a][8*i +: 8] = bus.req_wdata[8*i +: 8];
`ifdef SRAM_CTL_PARITY_EN
                            ref_bad[a][i] = bus.par_inject;
`endif
                        end
                    end
                end else begin
                    r.rdata = ref_mem[a];
                    r.err   = |ref_bad[a];
                end
            end
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, '0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_init_done", bus.init_done, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        model_clear();
        rst      = 1'b1;
        rel_edge = edge_no;
    endtask

    task automatic drain();
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        repeat (6) cycle();
        chk("drain_empty", DATA_W'(exp_q.size()), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        drive(1'b0, 1'b0, '0, '0, '0);
        bus.rsp_ready = 1'b1;
        set_inject(1'b0);
        model_clear();
        #1;
        do_reset(3);

        // A read held pending through the clear must wait for init_done.
        drive(1'b1, 1'b0, 25'd0, '0, '0);
        repeat (DEPTH + 1) cycle();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, ADDR_W'(a), '0, '0);
            cycle();
        end
        drain();

        // Byte-lane merge
        drive(1'b1, 1'b1, 25'd5, 64'h1122334455667788, 8'hFF); cycle();
        drive(1'b1, 1'b1, 25'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F); cycle();
        drive(1'b1, 1'b1, 25'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00); cycle();
        drive(1'b1, 1'b0, 25'd5, '0, '0);                      cycle();
        drain();

        // Write then read on consecutive cycles
        drive(1'b1, 1'b1, 25'd3, 64'h0123456789ABCDEF, 8'hFF); cycle();
        drive(1'b1, 1'b0, 25'd3, '0, '0);                      cycle();
        drain();

        // Backpressure: only two outstanding
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(i + 3), '0, '0);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        drain();

        // Out-of-range accesses must not alias
        drive(1'b1, 1'b1, 25'd32, 64'hDEADBEEFCAFEF00D, 8'hFF);  cycle();
        drive(1'b1, 1'b0, 25'd32, '0, '0);                       cycle();
        drive(1'b1, 1'b0, 25'd0, '0, '0);                        cycle();
        drive(1'b1, 1'b1, 25'h1FFFFFF, 64'h5555555555555555, 8'hFF); cycle();
        drive(1'b1, 1'b0, 25'd33, '0, '0);                       cycle();
        drive(1'b1, 1'b0, 25'd31, '0, '0);                       cycle();
        drain();

        // Parity injection (byte 0 only)
        set_inject(1'b1);
        drive(1'b1, 1'b1, 25'd7, 64'h00000000000000A5, 8'h01); cycle();
        set_inject(1'b0);
        drive(1'b1, 1'b0, 25'd7, '0, '0);                      cycle();
        drain();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            d = {$urandom, $urandom};
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, DEPTH + 3)),
                  d, NB'($urandom));
            set_inject($urandom_range(0, 7) == 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        set_inject(1'b0);
        drain();

        // Reset in RUN with responses queued: everything discarded and re-cleared
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 25'd9, 64'h0F0F0F0F0F0F0F0F, 8'hFF); cycle();
        drive(1'b1, 1'b1, 25'd10, 64'h0F0F0F0F0F0F0F0F, 8'hFF); cycle();
        drive(1'b0, 1'b0, '0, '0, '0);
        do_reset(2);
        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 25'd9, '0, '0);
        repeat (DEPTH + 1) cycle();
        drive(1'b1, 1'b0, 25'd10, '0, '0); cycle();
        drain();

        // Reset in the middle of INIT restarts the clear
        do_reset(2);
        repeat (10) cycle();
        do_reset(2);
        drive(1'b1, 1'b0, 25'd3, '0, '0);
        repeat (DEPTH + 1) cycle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
